// File: rtl/decode_pipe.sv
// RV32I decode stage: cracks an instruction into fields, immediate and control
// word, and registers the result behind a valid/ready handshake with an
// optional 2-entry skid buffer. Flush discards everything held and incoming.
module decode_pipe #(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instruction,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [6:0]      opcode,
    output logic [14:0]     ctrl
);

    // Bundle layout: {pc, imm, rd, rs1, rs2, func3, func7, opcode, ctrl}
    localparam int BW = 2*XLEN + 47;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // Shift func7 check; RV64 uses func7[0] as the sixth shamt bit.
    function automatic logic shamt_f7_ok(input logic [6:0] f7, input logic [6:0] pat);
        if (XLEN == 64) begin
            shamt_f7_ok = (f7[6:1] == pat[6:1]);
        end else begin
            shamt_f7_ok = (f7 == pat);
        end
    endfunction

    // ALU operation selected by func3 for the base register/immediate ops.
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  alu_from_f3 = ALU_ADD;
            3'b001:  alu_from_f3 = ALU_SLL;
            3'b010:  alu_from_f3 = ALU_SLT;
            3'b011:  alu_from_f3 = ALU_SLTU;
            3'b100:  alu_from_f3 = ALU_XOR;
            3'b101:  alu_from_f3 = ALU_SRL;
            3'b110:  alu_from_f3 = ALU_OR;
            default: alu_from_f3 = ALU_AND;
        endcase
    endfunction

    logic [6:0]      w_op;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [XLEN-1:0] w_imm;
    logic [14:0]     w_ctrl;
    logic            w_mwr, w_mrd, w_regw, w_alusrc, w_branch, w_jump, w_m2r, w_ill;
    logic [2:0]      w_aluop;
    logic [3:0]      w_aluctl;
    logic [BW-1:0]   w_bundle;
    logic            w_accept, w_xfer, w_in_ready;

    logic            r_out_valid;
    logic            r_skid_valid;
    logic [BW-1:0]   r_out;
    logic [BW-1:0]   r_skid;

    assign w_op = in_instruction[6:0];
    assign w_f3 = in_instruction[14:12];
    assign w_f7 = in_instruction[31:25];

    assign w_imm_i = XLEN'($signed(in_instruction[31:20]));
    assign w_imm_s = XLEN'($signed({in_instruction[31:25], in_instruction[11:7]}));
    assign w_imm_b = XLEN'($signed({in_instruction[31], in_instruction[7],
                                    in_instruction[30:25], in_instruction[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({in_instruction[31:12], 12'h000}));
    assign w_imm_j = XLEN'($signed({in_instruction[31], in_instruction[19:12],
                                    in_instruction[20], in_instruction[30:21], 1'b0}));

    // Opcode decode: control fields, immediate selection and illegal detection.
    always_comb begin
        w_mwr    = 1'b0;
        w_mrd    = 1'b0;
        w_regw   = 1'b0;
        w_alusrc = 1'b0;
        w_branch = 1'b0;
        w_jump   = 1'b0;
        w_m2r    = 1'b0;
        w_ill    = 1'b0;
        w_aluop  = 3'b000;
        w_aluctl = ALU_AND;
        w_imm    = '0;
        case (w_op)
            OP_LUI: begin
                w_aluop = 3'b100; w_alusrc = 1'b1; w_regw = 1'b1; w_aluctl = ALU_ADD; w_imm = w_imm_u;
            end
            OP_AUIPC: begin
                w_aluop = 3'b101; w_alusrc = 1'b1; w_regw = 1'b1; w_aluctl = ALU_ADD; w_imm = w_imm_u;
            end
            OP_JAL: begin
                w_aluop = 3'b011; w_alusrc = 1'b1; w_regw = 1'b1; w_jump = 1'b1;
                w_aluctl = ALU_ADD; w_imm = w_imm_j;
            end
            OP_JALR: begin
                w_aluop = 3'b111; w_alusrc = 1'b1; w_regw = 1'b1; w_jump = 1'b1;
                w_aluctl = ALU_ADD; w_imm = w_imm_i; w_ill = (w_f3 != 3'b000);
            end
            OP_BRANCH: begin
                w_aluop = 3'b001; w_branch = 1'b1; w_aluctl = ALU_SUB; w_imm = w_imm_b;
                w_ill = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            OP_LOAD: begin
                w_aluop = 3'b000; w_alusrc = 1'b1; w_mrd = 1'b1; w_m2r = 1'b1; w_regw = 1'b1;
                w_aluctl = ALU_ADD; w_imm = w_imm_i;
                w_ill = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
            OP_STORE: begin
                w_aluop = 3'b000; w_alusrc = 1'b1; w_mwr = 1'b1; w_aluctl = ALU_ADD; w_imm = w_imm_s;
                w_ill = (w_f3 >= 3'b011);
            end
            OP_IMM: begin
                w_aluop = 3'b010; w_alusrc = 1'b1; w_regw = 1'b1; w_imm = w_imm_i;
                case (w_f3)
                    3'b001: begin
                        w_aluctl = ALU_SLL;
                        w_ill    = !shamt_f7_ok(w_f7, 7'b0000000);
                    end
                    3'b101: begin
                        if (shamt_f7_ok(w_f7, 7'b0000000)) begin
                            w_aluctl = ALU_SRL;
                        end else if (shamt_f7_ok(w_f7, 7'b0100000)) begin
                            w_aluctl = ALU_SRA;
                        end else begin
                            w_aluctl = ALU_SRL;
                            w_ill    = 1'b1;
                        end
                    end
                    default: w_aluctl = alu_from_f3(w_f3);
                endcase
            end
            OP_REG: begin
                w_aluop = 3'b010; w_regw = 1'b1;
                if (w_f7 == 7'b0000000) begin
                    w_aluctl = alu_from_f3(w_f3);
                end else if ((w_f7 == 7'b0100000) && (w_f3 == 3'b000)) begin
                    w_aluctl = ALU_SUB;
                end else if ((w_f7 == 7'b0100000) && (w_f3 == 3'b101)) begin
                    w_aluctl = ALU_SRA;
                end else begin
                    w_aluctl = ALU_ADD;
                    w_ill    = 1'b1;
                end
            end
            OP_SYSTEM: begin
                w_aluop = 3'b110; w_imm = w_imm_i;
            end
            default: w_ill = 1'b1;
        endcase
        // Illegal bundles still flow but must not write state or redirect.
        w_ctrl = {w_aluctl, w_aluop, w_ill, w_m2r, w_jump & ~w_ill, w_branch & ~w_ill,
                  w_alusrc, w_regw & ~w_ill, w_mrd & ~w_ill, w_mwr & ~w_ill};
    end

    assign w_bundle = {in_pc, w_imm, in_instruction[11:7], in_instruction[19:15],
                       in_instruction[24:20], w_f3, w_f7, w_op, w_ctrl};

    assign w_in_ready = SKID_EN ? !r_skid_valid : (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_xfer     = r_out_valid && out_ready;

    // Output register and skid buffer; skid always drains before new input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out        <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_xfer) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out        <= w_bundle;
                r_out_valid  <= 1'b1;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            if (r_out_valid) begin
                r_skid       <= w_bundle;
                r_skid_valid <= 1'b1;
            end else begin
                r_out        <= w_bundle;
                r_out_valid  <= 1'b1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign {out_pc, imm, rd, rs1, rs2, func3, func7, opcode, ctrl} = r_out;

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed vector table, handshake corner sequences,
// then randomized traffic checked against a queue-based reference model.
module tb_decode_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instruction, in_pc, out_pc, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  func3;
    logic [6:0]  func7, opcode;
    logic [14:0] ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    decode_pipe #(.XLEN(32), .SKID_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .imm(imm), .rd(rd), .rs1(rs1), .rs2(rs2),
        .func3(func3), .func7(func7), .opcode(opcode), .ctrl(ctrl)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference decoder, written from the ISA rules with integer arithmetic.
    int alu_by_f3[8] = '{2, 4, 7, 9, 3, 5, 1, 0};

    task automatic ref_decode(input logic [31:0] ins, output logic [31:0] r_imm,
                              output logic [14:0] r_ctrl, output logic [14:0] r_mask,
                              output bit imm_known);
        int s, hi20, hi25, sgn, im, aop, actl;
        int mw, mr, rw, as, br, jp, m2r, ill;
        int f3, f7;
        s    = int'(ins);
        hi20 = s >>> 20;
        hi25 = s >>> 25;
        sgn  = s >>> 31;
        f3   = int'(ins[14:12]);
        f7   = int'(ins[31:25]);
        mw = 0; mr = 0; rw = 0; as = 0; br = 0; jp = 0; m2r = 0; ill = 0;
        aop = 0; actl = 0; im = 0; imm_known = 1'b1;
        case (int'(ins[6:0]))
            'h37: begin aop = 4; as = 1; rw = 1; actl = 2; im = (s >>> 12) * 4096; end
            'h17: begin aop = 5; as = 1; rw = 1; actl = 2; im = (s >>> 12) * 4096; end
            'h6F: begin
                aop = 3; as = 1; rw = 1; jp = 1; actl = 2;
                im = sgn * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            end
            'h67: begin aop = 7; as = 1; rw = 1; jp = 1; actl = 2; im = hi20; ill = (f3 != 0); end
            'h63: begin
                aop = 1; br = 1; actl = 6; ill = (f3 == 2 || f3 == 3);
                im = sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            end
            'h03: begin
                aop = 0; as = 1; mr = 1; m2r = 1; rw = 1; actl = 2; im = hi20;
                ill = (f3 == 3 || f3 == 6 || f3 == 7);
            end
            'h23: begin
                aop = 0; as = 1; mw = 1; actl = 2; im = hi25 * 32 + int'(ins[11:7]); ill = (f3 >= 3);
            end
            'h13: begin
                aop = 2; as = 1; rw = 1; im = hi20; actl = alu_by_f3[f3];
                if (f3 == 1) ill = (f7 != 0);
                if (f3 == 5) begin
                    if (f7 == 'h20) actl = 8;
                    else ill = (f7 != 0);
                end
            end
            'h33: begin
                aop = 2; rw = 1; im = 0;
                if (f7 == 0) actl = alu_by_f3[f3];
                else if (f7 == 'h20 && f3 == 0) actl = 6;
                else if (f7 == 'h20 && f3 == 5) actl = 8;
                else ill = 1;
            end
            'h73: begin aop = 6; im = hi20; end
            default: begin ill = 1; imm_known = 1'b0; end
        endcase
        if (ill != 0) begin
            mw = 0; mr = 0; rw = 0; br = 0; jp = 0;
        end
        r_imm  = 32'(im);
        r_ctrl = 15'(actl * 2048 + aop * 256 + ill * 128 + m2r * 64 + jp * 32 + br * 16
                     + as * 8 + rw * 4 + mr * 2 + mw);
        // The ALU selector of an illegal encoding carries no meaning.
        r_mask = (ill != 0) ? 15'h07FF : 15'h7FFF;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;
    ent_t q[$];

    task automatic check_head(input ent_t e);
        logic [31:0] e_imm;
        logic [14:0] e_ctrl, e_mask;
        bit          known;
        ref_decode(e.ins, e_imm, e_ctrl, e_mask, known);
        chk("rnd_pc", out_pc, e.pc);
        chk("rnd_fields", {rd, rs1, rs2, func3, func7, opcode},
            {e.ins[11:7], e.ins[19:15], e.ins[24:20], e.ins[14:12], e.ins[31:25], e.ins[6:0]});
        chk("rnd_ctrl", ctrl & e_mask, e_ctrl & e_mask);
        if (known) chk("rnd_imm", imm, e_imm);
    endtask

    logic [6:0] opc_list[10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        int          sel;
        r   = $urandom;
        sel = $urandom_range(0, 11);
        if (sel < 10) begin
            r[6:0] = opc_list[sel];
            if ($urandom_range(0, 1) == 0) r[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
        end else if (sel == 11) begin
            r = 32'h0;
        end
        return r;
    endfunction

    typedef struct {
        logic [31:0] ins;
        logic [31:0] imm;
        logic [14:0] ctrl;
        logic [14:0] mask;
        bit          imm_chk;
        logic [4:0]  rd;
        logic [4:0]  rs1;
    } vec_t;
    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'hFFF10093, 32'hFFFFFFFF, 15'h120C, 15'h7FFF, 1'b1, 5'd1,  5'd2};  // addi x1,x2,-1
        vecs[1] = '{32'hFE000EE3, 32'hFFFFFFFC, 15'h3110, 15'h7FFF, 1'b1, 5'd29, 5'd0};  // beq back -4
        vecs[2] = '{32'h00000000, 32'h00000000, 15'h0080, 15'h07FF, 1'b0, 5'd0,  5'd0};  // all zero
        vecs[3] = '{32'h40001033, 32'h00000000, 15'h1280, 15'h07FF, 1'b1, 5'd0,  5'd0};  // bad SLL func7
        vecs[4] = '{32'h0020B023, 32'h00000000, 15'h1088, 15'h07FF, 1'b1, 5'd0,  5'd1};  // store f3=011
        vecs[5] = '{32'h123452B7, 32'h12345000, 15'h140C, 15'h7FFF, 1'b1, 5'd5,  5'd8};  // lui
        vecs[6] = '{32'h402081B3, 32'h00000000, 15'h3204, 15'h7FFF, 1'b1, 5'd3,  5'd1};  // sub
        vecs[7] = '{32'h0080A203, 32'h00000008, 15'h104E, 15'h7FFF, 1'b1, 5'd4,  5'd1};  // lw
        vecs[8] = '{32'h4030D093, 32'h00000403, 15'h420C, 15'h7FFF, 1'b1, 5'd1,  5'd1};  // srai

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instruction = 32'h0; in_pc = 32'h0;
        #12;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_ctrl", ctrl, 15'h0);
        chk("reset_imm_pc", {imm, out_pc}, 64'h0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", in_ready, 1'b1);
        tick;

        // Directed table, one instruction per cycle, execute always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_instruction = vecs[i].ins; in_pc = 32'h1000 + 32'(4 * i);
            tick;
            chk("vec_valid", out_valid, 1'b1);
            chk("vec_pc", out_pc, 32'h1000 + 32'(4 * i));
            chk("vec_ctrl", ctrl & vecs[i].mask, vecs[i].ctrl & vecs[i].mask);
            chk("vec_regs", {rd, rs1}, {vecs[i].rd, vecs[i].rs1});
            if (vecs[i].imm_chk) chk("vec_imm", imm, vecs[i].imm);
        end
        in_valid = 1'b0;
        tick;
        chk("drain_valid", out_valid, 1'b0);

        // Back-pressure: two held, third waits, then all three leave in order.
        out_ready = 1'b0; in_valid = 1'b1;
        in_instruction = 32'hFFF10093; in_pc = 32'h100; tick;
        in_pc = 32'h104; tick;
        in_pc = 32'h108;
        chk("bp_in_ready_full", in_ready, 1'b0);
        tick;
        chk("bp_hold_pc", out_pc, 32'h100);
        chk("bp_hold_ready", in_ready, 1'b0);
        out_ready = 1'b1; tick;
        chk("bp_second_pc", {out_valid, out_pc}, {1'b1, 32'h104});
        tick;
        chk("bp_third_pc", {out_valid, out_pc}, {1'b1, 32'h108});
        in_valid = 1'b0; tick;
        chk("bp_empty", out_valid, 1'b0);

        // Flush with skid full and input offered.
        out_ready = 1'b0; in_valid = 1'b1;
        in_pc = 32'h200; tick;
        in_pc = 32'h204; tick;
        in_pc = 32'h300; flush = 1'b1; tick;
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick;
        chk("flush_stays_empty", out_valid, 1'b0);
        in_valid = 1'b1; in_pc = 32'h500; flush = 1'b1; tick;
        chk("flush_drops_accept", out_valid, 1'b0);
        flush = 1'b0; in_valid = 1'b0; tick;
        chk("flush_no_ghost", out_valid, 1'b0);

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h400; in_instruction = 32'h123452B7; tick;
        in_valid = 1'b0;
        chk("arst_pre_valid", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_ctrl", ctrl, 15'h0);
        rst = 1'b0;
        tick;
        chk("arst_after_ready", in_ready, 1'b1);

        // Randomized traffic against the queue model.
        q.delete();
        for (int c = 0; c < 800; c++) begin
            bit acc, xf;
            in_valid       = ($urandom_range(0, 3) != 0);
            in_instruction = gen_instr();
            in_pc          = $urandom & 32'hFFFF_FFFC;
            out_ready      = ($urandom_range(0, 2) != 0);
            flush          = ($urandom_range(0, 24) == 0);
            chk("rnd_in_ready", in_ready, (q.size() < 2));
            acc = in_valid && (q.size() < 2);
            xf  = (q.size() > 0) && out_ready;
            tick;
            if (flush) begin
                q.delete();
            end else begin
                if (xf) void'(q.pop_front());
                if (acc) q.push_back('{in_pc, in_instruction});
            end
            chk("rnd_out_valid", out_valid, (q.size() > 0));
            if (q.size() > 0) check_head(q[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
